// File: rtl/riscv_pkg.sv
// Shared RV64 core definitions used by the iterative divider.
package riscv_pkg;

    localparam int WIDTH = 64;

    // Divider operation, encoded exactly as funct3[1:0] of DIV/DIVU/REM/REMU.
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [WIDTH-1:0] DIV_MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;
    logic           borrow;

    // Because rem < divisor on entry, rem_shift < 2*divisor, so the top bit
    // of the (WIDTH+1)-bit difference is set exactly when the subtraction borrows.
    always_comb begin
        rem_shift = {rem, q[WIDTH-1]};
        diff      = rem_shift - {1'b0, divisor};
        borrow    = diff[WIDTH];
        rem_next  = borrow ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
        q_next    = {q[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/divider_seq.sv
// Iterative restoring divider for RV64M DIV/DIVU/REM/REMU, one quotient bit
// per clock, valid/ready on both sides, with flush.
// Optional macro DIV_SHORTCUT_EN: finish in one cycle when |a| < |b|.
module divider_seq
    import riscv_pkg::*;
#(
    parameter int WIDTH = riscv_pkg::WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    // Conditional two's complement negation, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    div_op_e          op_r;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             neg_q;
    logic             neg_r;

    div_op_e             op_in;
    logic                is_signed_in;
    logic                is_rem_in;
    logic                is_rem;
    logic signed [WIDTH-1:0] a_sgn;
    logic signed [WIDTH-1:0] b_sgn;
    logic                a_neg;
    logic                b_neg;
    logic [WIDTH-1:0]    abs_a;
    logic [WIDTH-1:0]    abs_b;
    logic                b_zero;
    logic                ovf;
    logic                accept;
    logic [WIDTH-1:0]    rem_next;
    logic [WIDTH-1:0]    q_next;

    assign op_in        = div_op_e'(op_i);
    assign is_signed_in = (op_in == DIV) || (op_in == REM);
    assign is_rem_in    = (op_in == REM) || (op_in == REMU);
    assign is_rem       = (op_r == REM) || (op_r == REMU);
    assign a_sgn        = operand_a;
    assign b_sgn        = operand_b;
    assign a_neg        = is_signed_in && (a_sgn < 0);
    assign b_neg        = is_signed_in && (b_sgn < 0);
    assign abs_a        = sign_fix(operand_a, a_neg);
    assign abs_b        = sign_fix(operand_b, b_neg);
    assign b_zero       = (operand_b == '0);
    assign ovf          = is_signed_in && (operand_a == MIN_INT) && (operand_b == '1);
    assign accept       = (state == IDLE) && valid_i;

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .q        (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_next   (q_next)
    );

    // Control: state, iteration counter and the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            result_o <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (b_zero) begin
                            result_o <= is_rem_in ? operand_a : '1;
                            state    <= DONE;
                        end else if (ovf) begin
                            result_o <= is_rem_in ? '0 : MIN_INT;
                            state    <= DONE;
`ifdef DIV_SHORTCUT_EN
                        end else if (abs_a < abs_b) begin
                            result_o <= is_rem_in ? operand_a : '0;
                            state    <= DONE;
`endif
                        end else begin
                            cnt   <= CNT_W'(WIDTH - 1);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt == '0) begin
                        result_o <= is_rem ? sign_fix(rem_next, neg_r) : sign_fix(q_next, neg_q);
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: capture operand magnitudes on accept, then iterate in CALC.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_r    <= op_in;
            rem     <= '0;
            quo     <= abs_a;
            divisor <= abs_b;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
        end else if (state == CALC) begin
            rem <= rem_next;
            quo <= q_next;
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Directed self-checking bench for divider_seq (WIDTH=64).
module tb_divider_seq;

    localparam int W = 64;
    localparam int NORM_LAT = W + 1;
`ifdef DIV_SHORTCUT_EN
    localparam int SC_LAT = 1;
`else
    localparam int SC_LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         flush_i;
    logic         valid_i;
    logic         ready_o;
    logic [1:0]   op_i;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] result_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    divider_seq dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o)
    );

    // Issue one op; lat counts edges from the accepting edge (1) until valid_o, -1 on timeout.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] res);
        op_i = op; operand_a = a; operand_b = b; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; operand_a = ~a; operand_b = ~b; op_i = ~op;
        lat = 1;
        while (!valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!valid_o) lat = -1;
        res = result_o;
    endtask

    task automatic drain;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (result_o !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result_o); end
        rst = 1'b0;
    endtask

    task automatic test_unsigned;
        int lat; logic [W-1:0] res;
        issue(2'b01, 64'd100, 64'd7, lat, res); drain();
        checks++; if (res !== 64'd14) begin failures++; $display("FAIL divu_100_7 got=%h exp=%h", res, 64'd14); end
        checks++; if (lat != NORM_LAT) begin failures++; $display("FAIL divu_latency got=%0d exp=%0d", lat, NORM_LAT); end
        issue(2'b11, 64'd100, 64'd7, lat, res); drain();
        checks++; if (res !== 64'd2) begin failures++; $display("FAIL remu_100_7 got=%h exp=%h", res, 64'd2); end
        issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, lat, res); drain();
        checks++; if (res !== 64'h7FFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL divu_max_2 got=%h exp=7fffffffffffffff", res); end
        issue(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, lat, res); drain();
        checks++; if (res !== 64'd1) begin failures++; $display("FAIL remu_max_2 got=%h exp=1", res); end
    endtask

    task automatic test_signed;
        int lat; logic [W-1:0] res;
        issue(2'b00, -64'sd100, 64'd7, lat, res); drain();
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFF2) begin failures++; $display("FAIL div_m100_7 got=%h exp=fffffffffffffff2", res); end
        checks++; if (lat != NORM_LAT) begin failures++; $display("FAIL div_latency got=%0d exp=%0d", lat, NORM_LAT); end
        issue(2'b10, -64'sd100, 64'd7, lat, res); drain();
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL rem_m100_7 got=%h exp=fffffffffffffffe", res); end
        issue(2'b10, 64'd100, -64'sd7, lat, res); drain();
        checks++; if (res !== 64'd2) begin failures++; $display("FAIL rem_100_m7 got=%h exp=2", res); end
        issue(2'b00, 64'h8000_0000_0000_0000, 64'd1, lat, res); drain();
        checks++; if (res !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL div_min_1 got=%h exp=8000000000000000", res); end
    endtask

    task automatic test_div_zero;
        int lat; logic [W-1:0] res;
        issue(2'b01, 64'd5, 64'd0, lat, res); drain();
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL divu_by_zero got=%h exp=ffffffffffffffff", res); end
        checks++; if (lat != 1) begin failures++; $display("FAIL divu_by_zero_latency got=%0d exp=1", lat); end
        issue(2'b10, -64'sd9, 64'd0, lat, res); drain();
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFF7) begin failures++; $display("FAIL rem_by_zero got=%h exp=fffffffffffffff7", res); end
        checks++; if (lat != 1) begin failures++; $display("FAIL rem_by_zero_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_overflow;
        int lat; logic [W-1:0] res;
        issue(2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, res); drain();
        checks++; if (res !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL div_overflow got=%h exp=8000000000000000", res); end
        checks++; if (lat != 1) begin failures++; $display("FAIL div_overflow_latency got=%0d exp=1", lat); end
        issue(2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, res); drain();
        checks++; if (res !== 64'd0) begin failures++; $display("FAIL rem_overflow got=%h exp=0", res); end
        checks++; if (lat != 1) begin failures++; $display("FAIL rem_overflow_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_shortcut;
        int lat; logic [W-1:0] res;
        issue(2'b01, 64'd3, 64'd10, lat, res); drain();
        checks++; if (res !== 64'd0) begin failures++; $display("FAIL divu_3_10 got=%h exp=0", res); end
        checks++; if (lat != SC_LAT) begin failures++; $display("FAIL divu_3_10_latency got=%0d exp=%0d", lat, SC_LAT); end
        issue(2'b10, -64'sd3, 64'd10, lat, res); drain();
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL rem_m3_10 got=%h exp=fffffffffffffffd", res); end
    endtask

    task automatic test_backpressure;
        int lat; logic [W-1:0] res;
        ready_i = 1'b0;
        issue(2'b01, 64'd100, 64'd7, lat, res);
        checks++; if (lat != NORM_LAT) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, NORM_LAT); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, valid_o); end
            checks++; if (result_o !== 64'd14) begin failures++; $display("FAIL bp_result cyc=%0d got=%h exp=e", i, result_o); end
            checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, ready_o); end
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", ready_o); end
    endtask

    task automatic test_flush;
        int lat; logic [W-1:0] res;
        op_i = 2'b01; operand_a = 64'd100; operand_b = 64'd7; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", valid_o); end
        checks++; if (result_o !== 64'd14) begin failures++; $display("FAIL flush_result_kept got=%h exp=e", result_o); end
        issue(2'b01, 64'd9, 64'd3, lat, res); drain();
        checks++; if (res !== 64'd3) begin failures++; $display("FAIL post_flush_divu got=%h exp=3", res); end
        checks++; if (lat != NORM_LAT) begin failures++; $display("FAIL post_flush_latency got=%0d exp=%0d", lat, NORM_LAT); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [W-1:0] res;
        op_i = 2'b01; operand_a = 64'd100; operand_b = 64'd7; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_calc_ready got=%b exp=1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_calc_valid got=%b exp=0", valid_o); end
        checks++; if (result_o !== 64'd0) begin failures++; $display("FAIL rst_calc_result got=%h exp=0", result_o); end
        ready_i = 1'b0;
        issue(2'b01, 64'd5, 64'd0, lat, res);
        checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL rst_done_pre got=%h exp=ffffffffffffffff", res); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ready_i = 1'b1;
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_done_valid got=%b exp=0", valid_o); end
        checks++; if (result_o !== 64'd0) begin failures++; $display("FAIL rst_done_result got=%h exp=0", result_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rst_done_ready got=%b exp=1", ready_o); end
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        op_i = 2'b00; operand_a = '0; operand_b = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_shortcut();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
